credit_tx: RTL and testbench

Credit-based transmitter that feeds a remote `fifo_flops` instance across a registered link with no backpressure wire. Holds one credit per free remote FIFO slot, accepts upstream data on a valid/ready handshake only while a credit is held, and launches each accepted word one cycle later. It regains a credit on each return pulse from the receiving side's pop. Sits at the producer end of every flop-FIFO channel that crosses a pipeline boundary.

---
 rtl/credit_pkg.sv | 11 +
 rtl/credit_counter.sv | 56 +++++
 rtl/credit_tx.sv | 68 ++++++
 tb/tb_credit_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared constants and types for credit-based flow control between a producer
// and a remote fifo_flops instance.
package credit_pkg;

    localparam int DEF_FIFO_DEPTH = 13;
    localparam int DEF_CREDITS    = DEF_FIFO_DEPTH;
    localparam int DEF_CNT_WIDTH  = $clog2(DEF_CREDITS + 1);

    typedef logic [DEF_CNT_WIDTH-1:0] credit_cnt_t;

endpackage : credit_pkg

// File: rtl/credit_counter.sv
// Saturating up/down counter with a sticky overflow flag. The count never
// leaves 0..MAX_VAL; an increment at MAX_VAL without a decrement is flagged.
module credit_counter #(
    parameter int WIDTH     = credit_pkg::DEF_CNT_WIDTH,
    parameter int MAX_VAL   = credit_pkg::DEF_CREDITS,
    parameter int RESET_VAL = credit_pkg::DEF_CREDITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] count_next_s;
    logic             ovf_hit_s;
    logic             overflow_r;

    // Next count: the sum is formed one bit wider, then clamped at both ends.
    always_comb begin
        sum_s        = {1'b0, count_r} + {{WIDTH{1'b0}}, inc} - {{WIDTH{1'b0}}, dec};
        ovf_hit_s    = 1'b0;
        count_next_s = sum_s[WIDTH-1:0];
        if (inc && !dec && (count_r == MAX_C)) begin
            count_next_s = MAX_C;
            ovf_hit_s    = 1'b1;
        end else if (dec && !inc && (count_r == {WIDTH{1'b0}})) begin
            count_next_s = {WIDTH{1'b0}};
        end else begin
            count_next_s = sum_s[WIDTH-1:0];
        end
    end

    // Count register and sticky overflow; only rst clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= RESET_C;
            overflow_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            overflow_r <= overflow_r | ovf_hit_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;
    assign overflow   = overflow_r;

endmodule : credit_counter

// File: rtl/credit_tx.sv
// Credit-based transmitter: accepts a word only while a credit is held and
// launches it to the remote FIFO on a registered strobe one cycle later.
module credit_tx
    import credit_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CREDITS    = DEF_CREDITS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  credit_return,
    output logic [CNT_WIDTH-1:0]  credits,
    output logic [CNT_WIDTH-1:0]  credits_next,
    output logic                  no_credit,
    output logic                  idle,
    output logic                  credit_overflow
);

    localparam logic [CNT_WIDTH-1:0] FULL_C = CNT_WIDTH'(CREDITS);

    logic                  fire_s;
    logic                  tx_valid_r;
    logic [DATA_WIDTH-1:0] tx_data_r;

    credit_counter #(
        .WIDTH     (CNT_WIDTH),
        .MAX_VAL   (CREDITS),
        .RESET_VAL (CREDITS)
    ) u_credit_counter (
        .clk        (clk),
        .rst        (rst),
        .dec        (fire_s),
        .inc        (credit_return),
        .count      (credits),
        .count_next (credits_next),
        .overflow   (credit_overflow)
    );

    // Ready depends only on the registered count, never on this cycle's inputs.
    assign push_ready = (credits != {CNT_WIDTH{1'b0}});
    assign fire_s     = push_valid && push_ready;
    assign no_credit  = (credits == {CNT_WIDTH{1'b0}});
    assign idle       = (credits == FULL_C) && !tx_valid_r;

    // Launch register: one strobe per fire, payload held between fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= {DATA_WIDTH{1'b0}};
        end else if (fire_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= push_data;
        end else begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= tx_data_r;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;

endmodule : credit_tx

// File: tb/tb_credit_tx.sv
// Self-checking bench for credit_tx: behavioural credit model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_credit_tx;
    import credit_pkg::*;

    localparam int DW = 8;
    localparam int CR = 13;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_data = '0;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          credit_return = 1'b0;
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_next;
    logic          no_credit;
    logic          idle;
    logic          credit_overflow;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Model state: plain integers following the credit rules.
    int m_credits = CR;
    int m_tx_valid = 0;
    int m_tx_data = 0;
    int m_ovf = 0;

    credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
        .push_data(push_data), .tx_valid(tx_valid), .tx_data(tx_data),
        .credit_return(credit_return), .credits(credits), .credits_next(credits_next),
        .no_credit(no_credit), .idle(idle), .credit_overflow(credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_fire();
        return (push_valid && m_credits > 0) ? 1 : 0;
    endfunction

    function automatic int m_next();
        int raw;
        raw = m_credits - m_fire() + (credit_return ? 1 : 0);
        return (raw > CR) ? CR : raw;
    endfunction

    // Model update on each edge; reset restores the starting values at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_credits = CR; m_tx_valid = 0; m_tx_data = 0; m_ovf = 0;
        end else begin
            int f;
            int raw;
            f = m_fire();
            raw = m_credits - f + (credit_return ? 1 : 0);
            if (raw > CR) m_ovf = 1;
            m_credits = (raw > CR) ? CR : raw;
            m_tx_valid = f;
            if (f == 1) m_tx_data = int'(push_data);
        end
    end

    // Compare every output against the model midway through each cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            credit_cnt_t exp_c;
            exp_c = credit_cnt_t'(m_credits);
            check("credits",      int'(credits), int'(exp_c));
            check("credits_next", int'(credits_next), m_next());
            check("push_ready",   int'(push_ready), (m_credits != 0) ? 1 : 0);
            check("no_credit",    int'(no_credit), (m_credits == 0) ? 1 : 0);
            check("idle",         int'(idle), (m_credits == CR && m_tx_valid == 0) ? 1 : 0);
            check("tx_valid",     int'(tx_valid), m_tx_valid);
            check("tx_data",      int'(tx_data), m_tx_data);
            check("overflow",     int'(credit_overflow), m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        cyc();
        rst = 1'b1;
        #1;
        cmp_en = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_credits", int'(credits), 13);
        check("rst_ready", int'(push_ready), 1);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_idle", int'(idle), 1);
        check("rst_ovf", int'(credit_overflow), 0);

        // Single send
        push_valid = 1'b1; push_data = 8'h42;
        cyc();
        push_valid = 1'b0; push_data = 8'h00;
        check("single_tx_valid", int'(tx_valid), 1);
        check("single_tx_data", int'(tx_data), 8'h42);
        check("single_credits", int'(credits), 12);
        cyc();
        check("single_tx_valid_drop", int'(tx_valid), 0);

        // Exhaust credits from full
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            push_valid = 1'b1; push_data = 8'(i);
            cyc();
            check("exh_tx_valid", int'(tx_valid), 1);
            check("exh_tx_data", int'(tx_data), i);
        end
        check("exh_credits", int'(credits), 0);
        check("exh_no_credit", int'(no_credit), 1);
        check("exh_ready", int'(push_ready), 0);
        push_data = 8'hFF;
        cyc();
        check("exh_14th_blocked", int'(tx_valid), 0);

        // Return at zero, pending word then fires
        credit_return = 1'b1;
        cyc();
        credit_return = 1'b0;
        check("ret0_credits", int'(credits), 1);
        check("ret0_ready", int'(push_ready), 1);
        cyc();
        push_valid = 1'b0;
        check("ret0_tx_valid", int'(tx_valid), 1);
        check("ret0_tx_data", int'(tx_data), 8'hFF);
        check("ret0_credits_after", int'(credits), 0);

        // Bring to 5 credits, then simultaneous fire and return
        credit_return = 1'b1;
        repeat (5) cyc();
        check("sim_pre_credits", int'(credits), 5);
        push_valid = 1'b1; push_data = 8'h5A;
        cyc();
        push_valid = 1'b0; credit_return = 1'b0;
        check("sim_credits", int'(credits), 5);
        check("sim_tx_valid", int'(tx_valid), 1);

        // Refill to full, then overflow
        credit_return = 1'b1;
        repeat (8) cyc();
        credit_return = 1'b0;
        cyc();
        check("full_idle", int'(idle), 1);
        credit_return = 1'b1;
        cyc();
        credit_return = 1'b0;
        check("ovf_credits", int'(credits), 13);
        check("ovf_flag", int'(credit_overflow), 1);
        repeat (3) cyc();
        check("ovf_sticky", int'(credit_overflow), 1);

        // Reset mid-burst after 3 fires
        push_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_data = 8'(8'h10 + i);
            cyc();
        end
        check("burst_credits", int'(credits), 10);
        rst = 1'b1; credit_return = 1'b1;
        #1;
        check("rstmid_ovf", int'(credit_overflow), 0);
        check("rstmid_credits", int'(credits), 13);
        check("rstmid_tx_valid", int'(tx_valid), 0);
        cyc();
        check("rstmid_ret_ignored", int'(credit_overflow), 0);
        rst = 1'b0; credit_return = 1'b0; push_valid = 1'b0;
        cyc();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            push_valid    = ($urandom_range(0, 99) < 60);
            push_data     = 8'($urandom);
            credit_return = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 35 : 60));
            rst           = ($urandom_range(0, 999) < 3);
            cyc();
        end
        rst = 1'b0; push_valid = 1'b0; credit_return = 1'b0;
        cyc();
        cyc();
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_credit_tx
